// File: rtl/neorv32_wb_arbiter_pkg.sv
// Shared types for the NEORV32 ibus/dbus to Wishbone-classic arbiter.
package neorv32_wb_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        rw;
        logic [3:0]  ben;
        logic [31:0] wdata;
    } req_t;

    localparam int DEFAULT_TIMEOUT = 255;

    // A port presents its captured request if one is waiting, otherwise the live inputs.
    function automatic req_t pick_req(input logic pending, input req_t cap, input req_t live);
        return pending ? cap : live;
    endfunction

endpackage

// File: rtl/neorv32_wb_req_latch.sv
// Per-port request holder: pending flag plus the captured request fields.
module neorv32_wb_req_latch
    import neorv32_wb_arbiter_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stb,
    input  logic [31:0] i_addr,
    input  logic        i_rw,
    input  logic [3:0]  i_ben,
    input  logic [31:0] i_wdata,
    input  logic        i_active,
    input  logic        i_clr,
    output logic        o_pending,
    output req_t        o_req
);

    logic r_pending;
    req_t r_req;
    logic w_accept;

    // A strobe while this port is already waiting or on the bus is dropped.
    assign w_accept = i_stb & ~r_pending & ~i_active;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= 1'b0;
            r_req     <= '0;
        end else if (i_clr) begin
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_pending <= 1'b1;
            r_req     <= {i_addr, i_rw, i_ben, i_wdata};
        end
    end

    assign o_pending = r_pending;
    assign o_req     = r_req;

    a_no_overlap : assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_stb && (r_pending || i_active)));

endmodule

// File: rtl/neorv32_wb_arbiter.sv
// Round-robin bridge of the NEORV32 ibus/dbus onto one Wishbone-classic master.
// state | meaning
// IDLE  | no Wishbone cycle; grant a pending or strobing port
// BUS   | cyc/stb high; wait for ack or timeout
module neorv32_wb_arbiter
    import neorv32_wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ibus_stb,
    input  logic [31:0] i_ibus_addr,
    input  logic        i_ibus_rw,
    input  logic [3:0]  i_ibus_ben,
    input  logic [31:0] i_ibus_wdata,
    output logic [31:0] o_ibus_rdata,
    output logic        o_ibus_ack,
    output logic        o_ibus_err,
    input  logic        i_dbus_stb,
    input  logic [31:0] i_dbus_addr,
    input  logic        i_dbus_rw,
    input  logic [3:0]  i_dbus_ben,
    input  logic [31:0] i_dbus_wdata,
    output logic [31:0] o_dbus_rdata,
    output logic        o_dbus_ack,
    output logic        o_dbus_err,
    output logic        o_core_cyc,
    output logic        o_core_stb,
    output logic        o_core_we,
    output logic [3:0]  o_core_wstrb,
    output logic [31:0] o_core_addr,
    output logic [31:0] o_core_data_out,
    input  logic [31:0] i_core_data_in,
    input  logic        i_core_ack
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    state_t r_state, w_state_nxt;
    port_t  r_grant, r_last_grant, w_win;
    logic   [CNT_W-1:0] r_cnt;

    logic   w_i_pend, w_d_pend, w_i_active, w_d_active, w_i_clr, w_d_clr;
    logic   w_i_req_v, w_d_req_v, w_grant_en, w_ack_hit, w_timeout;
    req_t   w_i_cap, w_d_cap, w_i_live, w_d_live, w_i_req, w_d_req, w_sel_req;

    logic        r_core_cyc, r_core_we;
    logic [3:0]  r_core_wstrb;
    logic [31:0] r_core_addr, r_core_data_out;
    logic        r_ibus_ack, r_ibus_err, r_dbus_ack, r_dbus_err;
    logic [31:0] r_ibus_rdata, r_dbus_rdata;

    assign w_i_active = (r_state == BUS) && (r_grant == PORT_I);
    assign w_d_active = (r_state == BUS) && (r_grant == PORT_D);
    assign w_i_clr    = w_grant_en && (w_win == PORT_I);
    assign w_d_clr    = w_grant_en && (w_win == PORT_D);

    neorv32_wb_req_latch u_ibus_latch (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_stb    (i_ibus_stb),
        .i_addr   (i_ibus_addr),
        .i_rw     (i_ibus_rw),
        .i_ben    (i_ibus_ben),
        .i_wdata  (i_ibus_wdata),
        .i_active (w_i_active),
        .i_clr    (w_i_clr),
        .o_pending(w_i_pend),
        .o_req    (w_i_cap)
    );

    neorv32_wb_req_latch u_dbus_latch (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_stb    (i_dbus_stb),
        .i_addr   (i_dbus_addr),
        .i_rw     (i_dbus_rw),
        .i_ben    (i_dbus_ben),
        .i_wdata  (i_dbus_wdata),
        .i_active (w_d_active),
        .i_clr    (w_d_clr),
        .o_pending(w_d_pend),
        .o_req    (w_d_cap)
    );

    // Same-cycle strobes bypass the latch so the grant costs no extra cycle.
    assign w_i_live  = {i_ibus_addr, i_ibus_rw, i_ibus_ben, i_ibus_wdata};
    assign w_d_live  = {i_dbus_addr, i_dbus_rw, i_dbus_ben, i_dbus_wdata};
    assign w_i_req   = pick_req(w_i_pend, w_i_cap, w_i_live);
    assign w_d_req   = pick_req(w_d_pend, w_d_cap, w_d_live);
    assign w_i_req_v = w_i_pend | i_ibus_stb;
    assign w_d_req_v = w_d_pend | i_dbus_stb;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_win       = PORT_I;
        w_grant_en  = 1'b0;
        w_ack_hit   = 1'b0;
        w_timeout   = 1'b0;
        if (r_state == IDLE) begin
            if (w_i_req_v || w_d_req_v) begin
                w_grant_en  = 1'b1;
                w_state_nxt = BUS;
                if (w_i_req_v && w_d_req_v)
                    w_win = (r_last_grant == PORT_I) ? PORT_D : PORT_I;
                else
                    w_win = w_d_req_v ? PORT_D : PORT_I;
            end
        end else begin
            // Ack takes priority over a timeout landing in the same cycle.
            if (i_core_ack) begin
                w_ack_hit   = 1'b1;
                w_state_nxt = IDLE;
            end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                w_timeout   = 1'b1;
                w_state_nxt = IDLE;
            end
        end
        w_sel_req = (w_win == PORT_D) ? w_d_req : w_i_req;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant         <= PORT_I;
            r_last_grant    <= PORT_I;
            r_cnt           <= '0;
            r_core_cyc      <= 1'b0;
            r_core_we       <= 1'b0;
            r_core_wstrb    <= 4'b0000;
            r_core_addr     <= '0;
            r_core_data_out <= '0;
            r_ibus_ack      <= 1'b0;
            r_ibus_err      <= 1'b0;
            r_ibus_rdata    <= '0;
            r_dbus_ack      <= 1'b0;
            r_dbus_err      <= 1'b0;
            r_dbus_rdata    <= '0;
        end else begin
            r_ibus_ack   <= 1'b0;
            r_ibus_err   <= 1'b0;
            r_ibus_rdata <= '0;
            r_dbus_ack   <= 1'b0;
            r_dbus_err   <= 1'b0;
            r_dbus_rdata <= '0;
            if (w_grant_en) begin
                r_grant         <= w_win;
                r_last_grant    <= w_win;
                r_cnt           <= '0;
                r_core_cyc      <= 1'b1;
                r_core_we       <= w_sel_req.rw;
                r_core_wstrb    <= w_sel_req.rw ? w_sel_req.ben : 4'b0000;
                r_core_addr     <= w_sel_req.addr;
                r_core_data_out <= w_sel_req.rw ? w_sel_req.wdata : 32'h0;
            end else if (w_ack_hit) begin
                r_core_cyc <= 1'b0;
                if (r_grant == PORT_D) begin
                    r_dbus_ack   <= 1'b1;
                    r_dbus_rdata <= r_core_we ? 32'h0 : i_core_data_in;
                end else begin
                    r_ibus_ack   <= 1'b1;
                    r_ibus_rdata <= r_core_we ? 32'h0 : i_core_data_in;
                end
            end else if (w_timeout) begin
                r_core_cyc <= 1'b0;
                if (r_grant == PORT_D) r_dbus_err <= 1'b1;
                else                   r_ibus_err <= 1'b1;
            end else if (r_state == BUS) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_core_cyc      = r_core_cyc;
    assign o_core_stb      = r_core_cyc;
    assign o_core_we       = r_core_we;
    assign o_core_wstrb    = r_core_wstrb;
    assign o_core_addr     = r_core_addr;
    assign o_core_data_out = r_core_data_out;
    assign o_ibus_ack      = r_ibus_ack;
    assign o_ibus_err      = r_ibus_err;
    assign o_ibus_rdata    = r_ibus_rdata;
    assign o_dbus_ack      = r_dbus_ack;
    assign o_dbus_err      = r_dbus_err;
    assign o_dbus_rdata    = r_dbus_rdata;

endmodule

// File: tb/tb_neorv32_wb_arbiter.sv
// Scoreboard bench: stimulus queues expected Wishbone requests and port responses; a monitor checks them.
module tb_neorv32_wb_arbiter;
    import neorv32_wb_arbiter_pkg::*;

    typedef struct {
        string       nm;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  wstrb;
        logic [31:0] data;
        int          cyc;
    } exp_req_t;

    typedef struct {
        string       nm;
        bit          port;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } exp_rsp_t;

    logic        clk, rst;
    logic        ibus_stb, ibus_rw, dbus_stb, dbus_rw;
    logic [31:0] ibus_addr, ibus_wdata, dbus_addr, dbus_wdata;
    logic [3:0]  ibus_ben, dbus_ben;
    logic [31:0] ibus_rdata, dbus_rdata;
    logic        ibus_ack, ibus_err, dbus_ack, dbus_err;
    logic        core_cyc, core_stb, core_we, core_ack;
    logic [3:0]  core_wstrb;
    logic [31:0] core_addr, core_data_out, core_data_in;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc_n = 0;
    exp_req_t    q_req[$];
    exp_rsp_t    q_rsp[$];

    int          ack_delay = -1;
    logic [31:0] ack_data = 32'h0;
    bit          slave_en = 1'b1;
    logic        man_ack = 1'b0;
    logic [31:0] man_data = 32'h0;
    int          zchk_seq = 0;
    string       zchk_nm = "";

    neorv32_wb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_ibus_stb     (ibus_stb),
        .i_ibus_addr    (ibus_addr),
        .i_ibus_rw      (ibus_rw),
        .i_ibus_ben     (ibus_ben),
        .i_ibus_wdata   (ibus_wdata),
        .o_ibus_rdata   (ibus_rdata),
        .o_ibus_ack     (ibus_ack),
        .o_ibus_err     (ibus_err),
        .i_dbus_stb     (dbus_stb),
        .i_dbus_addr    (dbus_addr),
        .i_dbus_rw      (dbus_rw),
        .i_dbus_ben     (dbus_ben),
        .i_dbus_wdata   (dbus_wdata),
        .o_dbus_rdata   (dbus_rdata),
        .o_dbus_ack     (dbus_ack),
        .o_dbus_err     (dbus_err),
        .o_core_cyc     (core_cyc),
        .o_core_stb     (core_stb),
        .o_core_we      (core_we),
        .o_core_wstrb   (core_wstrb),
        .o_core_addr    (core_addr),
        .o_core_data_out(core_data_out),
        .i_core_data_in (core_data_in),
        .i_core_ack     (core_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1);
    end

    // Wishbone slave: acks ack_delay cycles into each bus cycle, or follows manual drive.
    initial begin
        int age;
        age = 0;
        core_ack = 1'b0;
        core_data_in = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (!slave_en) begin
                core_ack = man_ack;
                core_data_in = man_data;
                age = 0;
            end else begin
                core_ack = 1'b0;
                core_data_in = 32'h0;
                if (core_cyc) begin
                    if (age == ack_delay) begin
                        core_ack = 1'b1;
                        core_data_in = ack_data;
                    end
                    age++;
                end else begin
                    age = 0;
                end
            end
        end
    end

    // Monitor
    initial begin
        bit          prev_cyc;
        int          zseen;
        bit          a, e;
        logic [31:0] rd;
        exp_req_t    er;
        exp_rsp_t    es;
        prev_cyc = 1'b0;
        zseen = 0;
        forever begin
            @(negedge clk);
            if (zchk_seq != zseen) begin
                zseen = zchk_seq;
                n_vec++;
                if ({ibus_rdata, dbus_rdata, ibus_ack, ibus_err, dbus_ack, dbus_err, core_cyc, core_stb,
                     core_we, core_wstrb, core_addr, core_data_out} !== '0) begin
                    n_err++;
                    $display("FAIL %s outputs got cyc=%0b stb=%0b we=%0b wstrb=%h addr=%h dout=%h ack=%0b/%0b err=%0b/%0b rdata=%h/%h want all 0",
                             zchk_nm, core_cyc, core_stb, core_we, core_wstrb, core_addr, core_data_out,
                             ibus_ack, dbus_ack, ibus_err, dbus_err, ibus_rdata, dbus_rdata);
                end
            end
            if (rst) begin
                prev_cyc = 1'b0;
            end else begin
                n_vec++;
                if ((!ibus_ack && ibus_rdata !== 32'h0) || (!dbus_ack && dbus_rdata !== 32'h0) ||
                    (ibus_ack && ibus_err) || (dbus_ack && dbus_err) || (core_stb !== core_cyc)) begin
                    n_err++;
                    $display("FAIL invariant cycle %0d got ack=%0b/%0b err=%0b/%0b rdata=%h/%h cyc=%0b stb=%0b",
                             cyc_n, ibus_ack, dbus_ack, ibus_err, dbus_err, ibus_rdata, dbus_rdata, core_cyc, core_stb);
                end
                if (core_cyc && !prev_cyc) begin
                    n_vec++;
                    if (q_req.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_core_cyc cycle %0d addr=%h, want no bus cycle", cyc_n, core_addr);
                    end else begin
                        er = q_req.pop_front();
                        if (core_addr !== er.addr || core_we !== er.we || core_wstrb !== er.wstrb ||
                            core_data_out !== er.data || cyc_n != er.cyc) begin
                            n_err++;
                            $display("FAIL %s got addr=%h we=%0b wstrb=%h dout=%h cyc=%0d want addr=%h we=%0b wstrb=%h dout=%h cyc=%0d",
                                     er.nm, core_addr, core_we, core_wstrb, core_data_out, cyc_n,
                                     er.addr, er.we, er.wstrb, er.data, er.cyc);
                        end
                    end
                end
                prev_cyc = core_cyc;
                for (int p = 0; p < 2; p++) begin
                    a  = (p == 1) ? dbus_ack : ibus_ack;
                    e  = (p == 1) ? dbus_err : ibus_err;
                    rd = (p == 1) ? dbus_rdata : ibus_rdata;
                    if (a || e) begin
                        n_vec++;
                        if (q_rsp.size() == 0) begin
                            n_err++;
                            $display("FAIL unexpected_rsp cycle %0d port=%0d ack=%0b err=%0b rdata=%h, want none",
                                     cyc_n, p, a, e, rd);
                        end else begin
                            es = q_rsp.pop_front();
                            if (es.port != p[0] || es.err != e || rd !== es.rdata || cyc_n != es.cyc || core_cyc) begin
                                n_err++;
                                $display("FAIL %s got port=%0d err=%0b rdata=%h cyc=%0d core_cyc=%0b want port=%0d err=%0b rdata=%h cyc=%0d core_cyc=0",
                                         es.nm, p, e, rd, cyc_n, core_cyc, es.port, es.err, es.rdata, es.cyc);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic exp_req(input string nm, input logic [31:0] addr, input bit we,
                           input logic [3:0] wstrb, input logic [31:0] data, input int cyc);
        exp_req_t x;
        x.nm = nm; x.addr = addr; x.we = we; x.wstrb = wstrb; x.data = data; x.cyc = cyc;
        q_req.push_back(x);
    endtask

    task automatic exp_rsp(input string nm, input bit port, input bit err,
                           input logic [31:0] rdata, input int cyc);
        exp_rsp_t x;
        x.nm = nm; x.port = port; x.err = err; x.rdata = rdata; x.cyc = cyc;
        q_rsp.push_back(x);
    endtask

    task automatic set_i(input logic [31:0] a, input bit rw, input logic [3:0] ben, input logic [31:0] wd);
        ibus_addr = a; ibus_rw = rw; ibus_ben = ben; ibus_wdata = wd;
    endtask

    task automatic set_d(input logic [31:0] a, input bit rw, input logic [3:0] ben, input logic [31:0] wd);
        dbus_addr = a; dbus_rw = rw; dbus_ben = ben; dbus_wdata = wd;
    endtask

    // Strobe the selected ports for exactly one cycle; t is the strobe cycle.
    task automatic fire(input bit si, input bit sd, output int t);
        @(posedge clk); #1;
        ibus_stb = si;
        dbus_stb = sd;
        t = cyc_n;
        @(posedge clk); #1;
        ibus_stb = 1'b0;
        dbus_stb = 1'b0;
    endtask

    task automatic zero_check(input string nm);
        zchk_nm = nm;
        zchk_seq++;
        @(negedge clk); #1;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while ((q_req.size() != 0 || q_rsp.size() != 0) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 100) begin
            $display("FAIL %s_drain got %0d req / %0d rsp outstanding, want 0/0", nm, q_req.size(), q_rsp.size());
            $fatal(1);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int t, t2;
        rst = 1'b1;
        ibus_stb = 1'b0; dbus_stb = 1'b0;
        set_i(32'h0, 1'b0, 4'h0, 32'h0);
        set_d(32'h0, 1'b0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        zero_check("reset_hold");
        @(posedge clk); #1;
        rst = 1'b0;
        zero_check("after_reset");

        // dbus read, ack two cycles into the bus cycle
        ack_delay = 2; ack_data = 32'hDEADBEEF;
        set_d(32'h100, 1'b0, 4'hF, 32'h5555_5555);
        fire(1'b0, 1'b1, t);
        exp_req("dbus_read_req", 32'h100, 1'b0, 4'b0000, 32'h0, t + 1);
        exp_rsp("dbus_read_rsp", 1'b1, 1'b0, 32'hDEADBEEF, t + 4);
        wait_done("dbus_read");

        // byte write, immediate ack
        ack_delay = 0; ack_data = 32'h1234_5678;
        set_d(32'h204, 1'b1, 4'b0100, 32'h00AB_0000);
        fire(1'b0, 1'b1, t);
        exp_req("byte_write_req", 32'h204, 1'b1, 4'b0100, 32'h00AB_0000, t + 1);
        exp_rsp("byte_write_rsp", 1'b1, 1'b0, 32'h0, t + 2);
        wait_done("byte_write");

        // new strobe in the cycle of its own ack pulse
        ack_delay = 0; ack_data = 32'h0000_00A5;
        set_d(32'h400, 1'b0, 4'hF, 32'h0);
        fire(1'b0, 1'b1, t);
        exp_req("resp_cycle_req1", 32'h400, 1'b0, 4'b0000, 32'h0, t + 1);
        exp_rsp("resp_cycle_rsp1", 1'b1, 1'b0, 32'h0000_00A5, t + 2);
        set_d(32'h404, 1'b0, 4'hF, 32'h0);
        fire(1'b0, 1'b1, t2);
        exp_req("resp_cycle_req2", 32'h404, 1'b0, 4'b0000, 32'h0, t2 + 1);
        exp_rsp("resp_cycle_rsp2", 1'b1, 1'b0, 32'h0000_00A5, t2 + 2);
        wait_done("resp_cycle");

        // simultaneous strobes from reset: dbus first, then alternation
        rst = 1'b1;
        zero_check("reset_before_pair");
        @(posedge clk); #1;
        rst = 1'b0;
        ack_delay = 1; ack_data = 32'h1111_1111;
        set_i(32'h1000, 1'b0, 4'hF, 32'h0);
        set_d(32'h2000, 1'b0, 4'hF, 32'h0);
        fire(1'b1, 1'b1, t);
        exp_req("pair1_d_req", 32'h2000, 1'b0, 4'b0000, 32'h0, t + 1);
        exp_rsp("pair1_d_rsp", 1'b1, 1'b0, 32'h1111_1111, t + 3);
        exp_req("pair1_i_req", 32'h1000, 1'b0, 4'b0000, 32'h0, t + 4);
        exp_rsp("pair1_i_rsp", 1'b0, 1'b0, 32'h1111_1111, t + 6);
        wait_done("pair1");

        set_i(32'h1100, 1'b0, 4'hF, 32'h0);
        set_d(32'h2100, 1'b1, 4'b0011, 32'h0000_BEEF);
        fire(1'b1, 1'b1, t);
        exp_req("pair2_d_req", 32'h2100, 1'b1, 4'b0011, 32'h0000_BEEF, t + 1);
        exp_rsp("pair2_d_rsp", 1'b1, 1'b0, 32'h0, t + 3);
        exp_req("pair2_i_req", 32'h1100, 1'b0, 4'b0000, 32'h0, t + 4);
        exp_rsp("pair2_i_rsp", 1'b0, 1'b0, 32'h1111_1111, t + 6);
        wait_done("pair2");

        set_d(32'h2200, 1'b0, 4'hF, 32'h0);
        fire(1'b0, 1'b1, t);
        exp_req("solo_d_req", 32'h2200, 1'b0, 4'b0000, 32'h0, t + 1);
        exp_rsp("solo_d_rsp", 1'b1, 1'b0, 32'h1111_1111, t + 3);
        wait_done("solo_d");

        set_i(32'h1200, 1'b1, 4'b1000, 32'hA500_0000);
        set_d(32'h2300, 1'b0, 4'hF, 32'h0);
        fire(1'b1, 1'b1, t);
        exp_req("pair3_i_req", 32'h1200, 1'b1, 4'b1000, 32'hA500_0000, t + 1);
        exp_rsp("pair3_i_rsp", 1'b0, 1'b0, 32'h0, t + 3);
        exp_req("pair3_d_req", 32'h2300, 1'b0, 4'b0000, 32'h0, t + 4);
        exp_rsp("pair3_d_rsp", 1'b1, 1'b0, 32'h1111_1111, t + 6);
        wait_done("pair3");

        // timeout with no ack, then a normal ibus read
        ack_delay = -1; ack_data = 32'h0;
        set_d(32'h500, 1'b0, 4'hF, 32'h0);
        fire(1'b0, 1'b1, t);
        exp_req("timeout_req", 32'h500, 1'b0, 4'b0000, 32'h0, t + 1);
        exp_rsp("timeout_err", 1'b1, 1'b1, 32'h0, t + 10);
        wait_done("timeout");

        ack_delay = 1; ack_data = 32'h0BAD_F00D;
        set_i(32'h600, 1'b0, 4'hF, 32'h0);
        fire(1'b1, 1'b0, t);
        exp_req("post_to_req", 32'h600, 1'b0, 4'b0000, 32'h0, t + 1);
        exp_rsp("post_to_rsp", 1'b0, 1'b0, 32'h0BAD_F00D, t + 3);
        wait_done("post_timeout");

        // ack arriving exactly on the timeout cycle
        ack_delay = 8; ack_data = 32'hCAFE_F00D;
        set_d(32'h700, 1'b0, 4'hF, 32'h0);
        fire(1'b0, 1'b1, t);
        exp_req("collide_req", 32'h700, 1'b0, 4'b0000, 32'h0, t + 1);
        exp_rsp("collide_rsp", 1'b1, 1'b0, 32'hCAFE_F00D, t + 10);
        wait_done("collide");

        // reset in BUS with ibus pending, then a late ack
        ack_delay = -1;
        set_d(32'h800, 1'b0, 4'hF, 32'h0);
        fire(1'b0, 1'b1, t);
        exp_req("midrst_req", 32'h800, 1'b0, 4'b0000, 32'h0, t + 1);
        set_i(32'h900, 1'b0, 4'hF, 32'h0);
        ibus_stb = 1'b1;
        @(posedge clk); #1;
        ibus_stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        zero_check("midrst_assert");
        @(posedge clk); #1;
        slave_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        man_ack = 1'b1; man_data = 32'h7777_7777;
        @(posedge clk); #1;
        man_ack = 1'b0; man_data = 32'h0;
        repeat (15) @(posedge clk);
        #1;
        zero_check("midrst_after");
        slave_en = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/neorv32_wb_arbiter.md
# neorv32_wb_arbiter

Bridges the NEORV32 CPU's two native bus ports (instruction `ibus`, data `dbus`) onto the single Wishbone-classic master port `core_*`. In the processor_ci top, this port is driven toward the Controller memory, or toward the simulation bench. The block latches single-cycle CPU requests, arbitrates them round-robin, and runs one Wishbone transaction at a time. Each transaction is bounded by a timeout counter. Responses are returned as single-cycle ack/err pulses on the originating port.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles of `core_cyc` without `core_ack` before the transaction is aborted with error.
- `clk`  in  1  core clock (connected to `clk_core`).
- `rst`  in  1  asynchronous, active-high reset (connected to `rst_core`).
- `ibus_stb` / `dbus_stb`  in  1  single-cycle request strobe.
- `ibus_addr` / `dbus_addr`  in  32  byte address; stable from strobe until response.
- `ibus_rw` / `dbus_rw`  in  1  1 = write, 0 = read.
- `ibus_ben` / `dbus_ben`  in  4  byte enables.
- `ibus_wdata` / `dbus_wdata`  in  32  write data.
- `ibus_rdata` / `dbus_rdata`  out  32  read data; 0 whenever ack is low.
- `ibus_ack` / `dbus_ack`  out  1  one-cycle response pulse.
- `ibus_err` / `dbus_err`  out  1  one-cycle error pulse (timeout).
- `core_cyc`, `core_stb`, `core_we`  out  1  Wishbone cycle, strobe and write enable.
- `core_wstrb`  out  4  byte strobes.
- `core_addr`, `core_data_out`  out  32  Wishbone address and write data.
- `core_data_in`  in  32  Wishbone read data.
- `core_ack`  in  1  Wishbone acknowledge.

## Operation
- **Request capture.** Each port has a pending flag plus a captured request (addr, rw, ben, wdata).
  - A strobe sets the flag on the next edge.
  - A strobe on a port whose request is already pending or active is a protocol violation. It is ignored and flagged by a simulation assertion.
- **State machine:** IDLE → BUS → IDLE.
  - **IDLE:** if any request is pending or being strobed this cycle, grant one, load the `core_*` registers, clear that port's pending flag, and go to BUS.
  - **BUS:** `core_cyc` and `core_stb` are held high. On `core_ack`, return to IDLE. On timeout, return to IDLE.
- **Arbitration.** A `last_grant` register resets to ibus.
  - If both ports request, the port not named by `last_grant` wins.
  - If only one port requests, it wins.
  - `last_grant` updates on every grant.
- **Wishbone outputs.**
  - `core_we` = rw.
  - `core_wstrb` = ben on writes, 4'b0000 on reads.
  - `core_data_out` = wdata on writes, 0 on reads.
  - `core_addr` = addr unmodified.
- **Response.**
  - On `core_ack`: the granted port's ack pulses next cycle, with rdata = `core_data_in` sampled at ack (reads), or 0 (writes).
  - On timeout: the granted port's err pulses with rdata = 0, and `core_cyc`/`core_stb` drop.
- **Timeout counter.** Cleared at grant and increments each BUS cycle without ack. Timeout fires when count == `TIMEOUT_CYCLES`. An ack arriving in the same cycle wins over the timeout.
- **Strobe during a response cycle.** A strobe arriving in the same cycle as its own port's ack/err pulse is legal and is captured normally.
- **Reset mid-transaction.** Reset clears all pending flags, returns the FSM to IDLE, and zeroes every output. A late `core_ack` arriving after reset is ignored in IDLE.

## Timing
- **Reset values:** every output is 0, FSM is IDLE, counter is 0, `last_grant` = ibus.
- **Grant latency:** strobe in cycle t with the FSM in IDLE → `core_cyc`/`core_stb` high in cycle t+1.
- **Completion:** `core_ack` high in cycle k → in cycle k+1, `core_cyc`/`core_stb` are low and the port's ack/rdata are valid.
- **Next grant:** earliest in cycle k+1 (IDLE evaluated in k+1), so `core_cyc` is high again at k+2. The minimum back-to-back period is therefore one dead cycle between Wishbone cycles.
- **Single-cycle pulses:** ack and err are exactly one cycle and never high at the same time.
- **Timeout:** with no ack, err pulses in cycle t+1+`TIMEOUT_CYCLES`+1.

## Structure
- Package `neorv32_wb_arbiter_pkg`:
  - `state_t` enum {IDLE, BUS}.
  - `port_t` enum {PORT_I, PORT_D}.
  - `req_t` packed struct {addr, rw, ben, wdata}.
  - `DEFAULT_TIMEOUT`.
- Sub-module `neorv32_wb_req_latch`, instantiated twice:
  - Holds the pending flag plus `req_t` for one port.
  - Inputs: stb, request fields, clear-on-grant.
  - Outputs: pending, captured `req_t`.
- The top holds the FSM, arbiter, timeout counter and response registers.

## Test plan
- **dbus read:** addr 0x100, `core_ack` 2 cycles after `core_cyc` with data 0xDEADBEEF → `core_we`=0, `core_wstrb`=0; `dbus_ack` one cycle with rdata 0xDEADBEEF; `ibus` outputs stay 0.
- **Byte write:** dbus write addr 0x204, ben 4'b0100, wdata 0x00AB0000 → `core_wstrb`=4'b0100, `core_data_out`=0x00AB0000; `dbus_ack` with rdata 0.
- **Simultaneous strobes from reset:** both ports strobe in the same cycle → dbus is granted first; ibus is granted at ack+1 with `core_cyc` high at ack+2. Repeat the simultaneous pair → order alternates.
- **Timeout:** `TIMEOUT_CYCLES`=8, no ack → `dbus_err` pulses 10 cycles after the strobe; `core_cyc` drops; a subsequent ibus request completes normally.
- **Ack/timeout collision:** `core_ack` asserted exactly on the timeout cycle → ack with data is returned, no err.
- **Mid-transaction reset:** reset asserted while in BUS with ibus pending → all outputs 0 immediately. A late `core_ack` after reset release produces no response, and the pending ibus request is dropped.
